// File: rtl/mmio_uart_hub_pkg.sv
// Shared definitions for the memory-mapped UART transmit hub: register offsets,
// STATUS/CTRL bit positions and the per-channel serializer state encoding.
package mmio_uart_hub_pkg;

  // Byte offsets of the registers inside one channel's 16-byte slot
  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_LEVEL_LSB = 8;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_IRQ_EN = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

endpackage

// File: rtl/mmio_uart_hub_chan.sv
// uart_tx_chan: one hub channel -- TX FIFO, baud counter, 8N1 serializer, STATUS/CTRL.
// CTRL.irq_en and the TX-empty interrupt exist only when MMIO_UART_HUB_IRQ_EN is defined.
module uart_tx_chan
  import mmio_uart_hub_pkg::*;
#(
  parameter int DIV        = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  reg_off,
  input  logic [7:0]  wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(DIV);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      level;
  logic             full, empty;
  logic             push_req, push_ok, pop, flush;
  logic             ovf, ovf_set, ovf_clr;
  logic             en, irq_en, ctrl_wr;

  tx_state_e        state, state_d;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             baud_done;

  assign full  = (level == (AW+1)'(FIFO_DEPTH));
  assign empty = (level == '0);

  assign push_req = wr_en && (reg_off == OFF_TXDATA);
  assign ctrl_wr  = wr_en && (reg_off == OFF_CTRL);
  assign flush    = ctrl_wr && wdata[CTRL_FLUSH];
  assign ovf_clr  = wr_en && (reg_off == OFF_STATUS) && wdata[ST_OVF];
  // A full FIFO still takes the byte when a slot frees up on the same edge.
  assign push_ok  = push_req && (!full || pop || flush);
  assign ovf_set  = push_req && !push_ok;

  // NOTE: storage has no reset; emptiness is tracked by the pointers and level alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // NOTE: all state updates in clocked blocks use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      en     <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (flush) begin
        // Flush discards everything queued before this edge, keeping only a same-cycle push.
        rd_ptr <= wr_ptr;
        level  <= push_ok ? (AW+1)'(1) : '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        case ({push_ok, pop})
          2'b10:   level <= level + (AW+1)'(1);
          2'b01:   level <= level - (AW+1)'(1);
          default: level <= level;
        endcase
      end
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (ctrl_wr) en <= wdata[CTRL_EN];
    end
  end

`ifdef MMIO_UART_HUB_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst)          irq_en <= 1'b0;
    else if (ctrl_wr) irq_en <= wdata[CTRL_IRQ_EN];
  end
  assign irq = irq_en && empty && (state == S_IDLE);
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  assign baud_done = (cnt == CNT_W'(DIV - 1));

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (en && !empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: if (baud_done) state_d = S_DATA;
      S_DATA:  if (baud_done && bit_idx == 3'd7) state_d = S_STOP;
      S_STOP:  if (baud_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state <= state_d;
      if (state == S_IDLE) begin
        cnt     <= '0;
        bit_idx <= '0;
        tx      <= !pop;
        if (pop) shift <= mem[rd_ptr];
      end else if (!baud_done) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
        case (state)
          S_START: begin
            tx    <= shift[0];
            shift <= shift >> 1;
          end
          S_DATA: begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              tx <= 1'b1;
            end else begin
              tx    <= shift[0];
              shift <= shift >> 1;
            end
          end
          default: tx <= 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_off)
      OFF_STATUS: begin
        rdata[ST_BUSY]              = !empty || (state != S_IDLE);
        rdata[ST_FULL]              = full;
        rdata[ST_EMPTY]             = empty;
        rdata[ST_OVF]               = ovf;
        rdata[ST_LEVEL_LSB +: 8]    = 8'(level);
      end
      OFF_CTRL: begin
        rdata[CTRL_EN]     = en;
        rdata[CTRL_IRQ_EN] = irq_en;
      end
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/mmio_uart_hub.sv
// mmio_uart_hub: address decode and read mux for NUM_CH memory-mapped UART TX channels.
// Defining MMIO_UART_HUB_IRQ_EN enables the per-channel TX-empty interrupt ORed onto irq.
module mmio_uart_hub
  import mmio_uart_hub_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_4000,
  parameter int          NUM_CH     = 2,
  parameter int          FIFO_DEPTH = 16,
  parameter int          CLK_HZ     = 100_000_000,
  parameter int          BAUD       = 115200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [31:0]       rdata,
  output logic              hit,
  output logic [NUM_CH-1:0] tx,
  output logic              irq
);

  localparam int          DIV     = CLK_HZ / BAUD;
  localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + 33'(16 * NUM_CH);

  logic [31:0]       off;
  logic [NUM_CH-1:0] ch_sel;
  logic [NUM_CH-1:0] ch_irq;
  logic [31:0]       ch_rdata [NUM_CH];
  logic              unused_ok;

  // Compare in 33 bits so a window ending at the top of the address space still decodes.
  assign hit = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < WIN_END);
  assign off = addr - BASE_ADDR;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign ch_sel[n] = hit && (off[31:4] == 28'(n));

    uart_tx_chan #(
      .DIV        (DIV),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (mem_write && ch_sel[n]),
      .reg_off ({off[3:2], 2'b00}),
      .wdata   (wdata[7:0]),
      .rdata   (ch_rdata[n]),
      .tx      (tx[n]),
      .irq     (ch_irq[n])
    );
  end

  always_comb begin
    rdata = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (mem_read && ch_sel[n]) rdata = rdata | ch_rdata[n];
    end
  end

  assign irq = |ch_irq;

  assign unused_ok = &{1'b0, wdata[31:8], off[1:0]};

endmodule
